// File: rtl/decoder_scan_n_pkg.sv
// decoder_pkg: shared definitions for the scanning N-to-2^N decoder.
//   MODE_DIRECT / MODE_SCAN : values of the mode input
//   state_e                 : controller states (IDLE, DIRECT, SCAN)
//   onehot()                : one-hot of a select value, MAX_OUTS bits wide;
//                             callers size-cast down to their own 2**SEL_W.
package decoder_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIRECT = 2'd1,
    ST_SCAN   = 2'd2
  } state_e;

  // Widest select supported by onehot(); SEL_W must not exceed this.
  localparam int MAX_SEL_W = 8;
  localparam int MAX_OUTS  = 1 << MAX_SEL_W;

  function automatic logic [MAX_OUTS-1:0] onehot(input logic [MAX_SEL_W-1:0] sel);
    onehot      = '0;
    onehot[sel] = 1'b1;
  endfunction

endpackage

// File: rtl/decoder_scan_n_dwell_timer.sv
// dwell_timer: dwell counter for the scan sweep.
//   clk, rst_n : clock, async active-low reset
//   clear_i    : force count to 0 (highest priority)
//   run_i      : count this cycle; otherwise the count holds
//   dwell_i    : live hold threshold
//   tick_o     : run_i and count >= dwell_i; the count self-clears on tick
module dwell_timer #(
  parameter int DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear_i,
  input  logic               run_i,
  input  logic [DWELL_W-1:0] dwell_i,
  output logic               tick_o
);

  logic [DWELL_W-1:0] cnt_q, cnt_d;

  // >= rather than == so a dwell lowered below the current count
  // advances on the very next edge instead of waiting for a wrap.
  assign tick_o = run_i && (cnt_q >= dwell_i);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)     cnt_d = '0;
    else if (tick_o) cnt_d = '0;
    else if (run_i)  cnt_d = cnt_q + DWELL_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/decoder_scan_n.sv
// decoder_scan_n: registered N-to-2^N one-hot decoder with a dwell-timed
// scan mode for multiplexed digit / keypad row selection.
//   clk, rst_n : clock, async active-low reset
//   en         : 0 forces outputs idle and freezes idx / dwell count
//   mode       : 0 = direct decode of I, 1 = free-running scan
//   I          : select value (direct mode)
//   dwell      : scan hold; each index is held dwell+1 cycles
//   y          : registered one-hot (one-cold when ACTIVE_LOW)
//   idx        : index currently driven on y
//   wrap       : one-cycle pulse when the scan index wraps to 0
module decoder_scan_n
  import decoder_pkg::*;
#(
  parameter int SEL_W      = 2,
  parameter int DWELL_W    = 16,
  parameter int ACTIVE_LOW = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      I,
  input  logic [DWELL_W-1:0]    dwell,
  output logic [(2**SEL_W)-1:0] y,
  output logic [SEL_W-1:0]      idx,
  output logic                  wrap
);

  localparam int OUTS = 2 ** SEL_W;

  function automatic logic [OUTS-1:0] oh(input logic [SEL_W-1:0] s);
    oh = OUTS'(onehot(MAX_SEL_W'(s)));
  endfunction

  state_e          state_q;
  logic [SEL_W-1:0] idx_q;
  logic [OUTS-1:0]  y_q;      // active-high image of y
  logic             wrap_q;
  logic             fresh_q;  // sweep must restart at 0 on next scan cycle
  logic             restart;
  logic             tmr_clear, tmr_run, tick;

  // A sweep restarts after reset and after any direct-mode cycle, even
  // if idle cycles sit in between; an en drop inside scan resumes.
  assign restart   = fresh_q || (state_q == ST_DIRECT);
  assign tmr_clear = en && ((mode == MODE_DIRECT) || restart);
  assign tmr_run   = en && (mode == MODE_SCAN) && !restart;

  dwell_timer #(.DWELL_W(DWELL_W)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (tmr_clear),
    .run_i   (tmr_run),
    .dwell_i (dwell),
    .tick_o  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      y_q     <= '0;
      wrap_q  <= 1'b0;
      fresh_q <= 1'b1;
    end else begin
      wrap_q <= 1'b0;
      if (!en) begin
        state_q <= ST_IDLE;
        y_q     <= '0;
        fresh_q <= restart;
      end else if (mode == MODE_DIRECT) begin
        state_q <= ST_DIRECT;
        idx_q   <= I;
        y_q     <= oh(I);
        fresh_q <= 1'b0;
      end else begin
        state_q <= ST_SCAN;
        fresh_q <= 1'b0;
        if (restart) begin
          idx_q <= '0;
          y_q   <= oh('0);
        end else if (tick) begin
          idx_q  <= idx_q + SEL_W'(1);
          y_q    <= oh(idx_q + SEL_W'(1));
          wrap_q <= &idx_q;
        end else begin
          y_q <= oh(idx_q);
        end
      end
    end
  end

  assign y    = (ACTIVE_LOW != 0) ? ~y_q : y_q;
  assign idx  = idx_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_decoder_scan_n.sv
module tb_decoder_scan_n;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        mode = 1'b0;
  logic [2:0]  I = '0;
  logic [15:0] dwell = '0;

  logic [3:0] y_a, y_b;
  logic [1:0] idx_a, idx_b;
  logic       wrap_a, wrap_b;
  logic [7:0] y_c;
  logic [2:0] idx_c;
  logic       wrap_c;

  always #5 clk = ~clk;

  decoder_scan_n #(.SEL_W(2), .DWELL_W(16), .ACTIVE_LOW(0)) u_a (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .I(I[1:0]), .dwell(dwell),
    .y(y_a), .idx(idx_a), .wrap(wrap_a));
  decoder_scan_n #(.SEL_W(2), .DWELL_W(16), .ACTIVE_LOW(1)) u_b (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .I(I[1:0]), .dwell(dwell),
    .y(y_b), .idx(idx_b), .wrap(wrap_b));
  decoder_scan_n #(.SEL_W(3), .DWELL_W(16), .ACTIVE_LOW(0)) u_c (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .I(I), .dwell(dwell),
    .y(y_c), .idx(idx_c), .wrap(wrap_c));

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: a scan position plus cycles already spent there; each
  // position lasts dwell+1 cycles. Index 0 = u_a, 1 = u_b, 2 = u_c.
  int m_outs[3]  = '{4, 4, 8};
  int m_idx[3]   = '{0, 0, 0};
  int m_cnt[3]   = '{0, 0, 0};
  bit m_fresh[3] = '{1, 1, 1};
  bit m_on[3]    = '{0, 0, 0};
  bit m_wrap[3]  = '{0, 0, 0};

  always @(posedge clk or negedge rst_n) begin
    for (int d = 0; d < 3; d++) begin
      if (!rst_n) begin
        m_idx[d] = 0; m_cnt[d] = 0; m_fresh[d] = 1; m_on[d] = 0; m_wrap[d] = 0;
      end else begin
        m_wrap[d] = 0;
        if (!en) begin
          m_on[d] = 0;
        end else if (!mode) begin
          m_on[d] = 1; m_idx[d] = int'(I) % m_outs[d]; m_cnt[d] = 0; m_fresh[d] = 1;
        end else begin
          m_on[d] = 1;
          if (m_fresh[d]) begin
            m_idx[d] = 0; m_cnt[d] = 0; m_fresh[d] = 0;
          end else if (m_cnt[d] >= int'(dwell)) begin
            m_idx[d] = (m_idx[d] + 1) % m_outs[d];
            m_cnt[d] = 0;
            m_wrap[d] = (m_idx[d] == 0);
          end else begin
            m_cnt[d]++;
          end
        end
      end
    end
  end

  task automatic cmp(input string nm, input logic [7:0] ay, input int aidx,
                     input logic aw, input int d, input logic [7:0] inv);
    logic [7:0] ey;
    ey = m_on[d] ? (8'd1 << m_idx[d]) : 8'd0;
    ey = ey ^ inv;
    chk({"y_", nm}, 32'(ay), 32'(ey));
    chk({"idx_", nm}, 32'(aidx), 32'(m_idx[d]));
    chk({"wrap_", nm}, 32'(aw), 32'(m_wrap[d]));
  endtask

  always @(negedge clk) begin
    cmp("a", {4'b0, y_a}, int'(idx_a), wrap_a, 0, 8'h00);
    cmp("b", {4'b0, y_b}, int'(idx_b), wrap_b, 1, 8'h0F);
    cmp("c", y_c, int'(idx_c), wrap_c, 2, 8'h00);
    chk("onehot_c", 32'($countones(y_c)), m_on[2] ? 32'd1 : 32'd0);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  logic [3:0] dir_exp[4]  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
  int         scan_seq[13] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};
  logic [3:0] al_exp[4]   = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  initial begin
    // Reset and direct decode
    en = 1'b1; mode = 1'b0; I = 3'd0;
    tick();
    chk("rst_y_a", 32'(y_a), 32'h0);
    chk("rst_y_b", 32'(y_b), 32'hF);
    chk("rst_idx_a", 32'(idx_a), 32'h0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      I = 3'(i);
      tick();
      chk("direct_y_a", 32'(y_a), 32'(dir_exp[i]));
    end
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_y_a", 32'(y_a), 32'h0);
    chk("async_rst_idx_a", 32'(idx_a), 32'h0);
    chk("async_rst_y_b", 32'(y_b), 32'hF);

    // Scan, dwell=2
    mode = 1'b1; dwell = 16'd2;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 13; k++) begin
      tick();
      chk("scan2_idx_a", 32'(idx_a), 32'(scan_seq[k]));
      chk("scan2_y_a", 32'(y_a), 32'(4'b0001 << scan_seq[k]));
      chk("scan2_wrap_a", 32'(wrap_a), (k == 12) ? 32'd1 : 32'd0);
    end

    // Scan, dwell=0, active-low instance
    rst_n = 1'b0; dwell = 16'd0;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("scan0_y_b", 32'(y_b), 32'(al_exp[k % 4]));
      chk("scan0_wrap_b", 32'(wrap_b), (k % 4 == 0 && k > 0) ? 32'd1 : 32'd0);
    end
    en = 1'b0;
    tick();
    chk("off_y_b", 32'(y_b), 32'hF);
    chk("off_wrap_b", 32'(wrap_b), 32'h0);
    en = 1'b1;

    // Enable freeze at idx=2, count=1 with dwell=3
    rst_n = 1'b0; dwell = 16'd3;
    tick();
    rst_n = 1'b1;
    repeat (10) tick();
    chk("frz_start_idx_a", 32'(idx_a), 32'd2);
    en = 1'b0;
    repeat (5) begin
      tick();
      chk("frz_y_a", 32'(y_a), 32'h0);
      chk("frz_wrap_a", 32'(wrap_a), 32'h0);
      chk("frz_idx_a", 32'(idx_a), 32'd2);
    end
    en = 1'b1;
    tick(); chk("frz_res1_idx_a", 32'(idx_a), 32'd2);
    tick(); chk("frz_res2_idx_a", 32'(idx_a), 32'd2);
    tick(); chk("frz_adv_idx_a", 32'(idx_a), 32'd3);
    chk("frz_adv_y_a", 32'(y_a), 32'b1000);

    // Live dwell lowering, then mode switches
    rst_n = 1'b0; dwell = 16'd15;
    tick();
    rst_n = 1'b1;
    repeat (43) tick();
    chk("live_idx_a", 32'(idx_a), 32'd2);
    dwell = 16'd4;
    tick();
    chk("live_adv_idx_a", 32'(idx_a), 32'd3);
    mode = 1'b0; I = 3'd1;
    tick();
    chk("sw_direct_y_a", 32'(y_a), 32'b0010);
    chk("sw_direct_idx_a", 32'(idx_a), 32'd1);
    mode = 1'b1;
    tick();
    chk("sw_scan_idx_a", 32'(idx_a), 32'd0);
    chk("sw_scan_y_a", 32'(y_a), 32'b0001);
    chk("sw_scan_wrap_a", 32'(wrap_a), 32'd0);

    // Width sweep on the 8-output instance, dwell=1
    rst_n = 1'b0; dwell = 16'd1;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 32; k++) begin
      tick();
      chk("sweep_idx_c", 32'(idx_c), 32'((k / 2) % 8));
      chk("sweep_wrap_c", 32'(wrap_c), (k == 16) ? 32'd1 : 32'd0);
    end

    // Randomised traffic, checked by the reference every cycle
    for (int n = 0; n < 3000; n++) begin
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 199) == 0) rst_n = 1'b0;
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 19) == 0) mode = ~mode;
      I = 3'($urandom);
      if ($urandom_range(0, 29) == 0)
        dwell = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 40)) : 16'($urandom_range(0, 3));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
